// File: rtl/sm3_pkg.sv
// sm3_pkg: shared constants and types for the SM3 message controller.
//   IV        - initial chaining value V
//   WORD_W    - message word width
//   BLK_WORDS - words per 512-bit block
//   BLK_W     - block width
//   V_W       - chaining value / digest width
//   state_t   - controller state (FILL / RUN / OUT)
package sm3_pkg;
  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int BLK_W     = WORD_W * BLK_WORDS;
  localparam int V_W       = 256;

  localparam logic [V_W-1:0] IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/sm3_pad_word.sv
// sm3_pad_word: masks the unused bytes of the final message word and places
// the 0x80 padding byte straight after the last valid byte.
//   data   in  message word, byte 0 in [31:24]
//   last   in  word is the last of the message
//   bytes  in  valid byte count on the last word (5..7 behave as 4)
//   word   out padded word
//   nbytes out effective valid byte count 0..4
module sm3_pad_word
  import sm3_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic              last,
  input  logic [2:0]        bytes,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        nbytes
);
  always_comb begin
    nbytes = 3'd4;
    if (last && bytes < 3'd4) nbytes = bytes;
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes)       word[31-8*b -: 8] = data[31-8*b -: 8];
      else if (3'(b) == nbytes) word[31-8*b -: 8] = 8'h80;
    end
  end
endmodule

// File: rtl/sm3_msg_ctrl.sv
// sm3_msg_ctrl: SM3 message controller. Takes a big-endian 32-bit word
// stream, pads it (0x80, zero fill, 64-bit bit length), builds 512-bit
// blocks, drives an external compression core while chaining V, and hands
// the digest out over a valid/ready handshake.
//   in_valid/in_ready/in_data/in_last/in_bytes  message word stream
//   cf_start/cf_block/cf_v_in                  compression request
//   cf_done/cf_v_out                           compression result
//   hash_valid/hash/hash_ready                 digest output
//   busy                                       high unless idle at word 0
module sm3_msg_ctrl
  import sm3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              cf_start,
  output logic [BLK_W-1:0]  cf_block,
  output logic [V_W-1:0]    cf_v_in,
  input  logic              cf_done,
  input  logic [V_W-1:0]    cf_v_out,
  output logic              hash_valid,
  output logic [V_W-1:0]    hash,
  input  logic              hash_ready,
  output logic              busy
);
  state_t state, state_nxt;

  // blk[15] holds word 0 so the packed array maps straight onto cf_block.
  logic [BLK_WORDS-1:0][WORD_W-1:0] blk;
  logic [V_W-1:0]    v;
  logic [3:0]        idx;
  logic [63:0]       len, len_nxt;
  logic              final_f, extra, p80;
  logic [WORD_W-1:0] pad_word;
  logic [2:0]        pad_bytes;
  logic              in_fire, done_fire;

  sm3_pad_word u_pad (
    .data   (in_data),
    .last   (in_last),
    .bytes  (in_bytes),
    .word   (pad_word),
    .nbytes (pad_bytes)
  );

  assign in_fire  = in_valid && in_ready;
  // A result in the same cycle as the start pulse cannot belong to this
  // block; only one result per RUN is taken because RUN is left on it.
  assign done_fire = (state == RUN) && cf_done && !cf_start;
  assign len_nxt  = len + (in_last ? {58'd0, pad_bytes, 3'd0} : 64'd32);

  assign cf_block = blk;
  assign cf_v_in  = v;
  assign hash     = v;
  assign busy     = !(state == FILL && idx == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    hash_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || idx == 4'd15)) state_nxt = RUN;
      end
      RUN: begin
        if (done_fire) state_nxt = final_f ? OUT : (extra ? RUN : FILL);
      end
      OUT: begin
        hash_valid = 1'b1;
        if (hash_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk      <= '0;
      v        <= IV;
      idx      <= '0;
      len      <= '0;
      final_f  <= 1'b0;
      extra    <= 1'b0;
      p80      <= 1'b0;
      cf_start <= 1'b0;
    end else begin
      cf_start <= 1'b0;
      case (state)
        FILL: if (in_fire) begin
          blk[4'd15 - idx] <= pad_word;
          len              <= len_nxt;
          if (!in_last) begin
            if (idx == 4'd15) begin
              final_f  <= 1'b0;
              cf_start <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            for (int i = 0; i < BLK_WORDS; i++)
              if (4'(i) > idx) blk[4'(15 - i)] <= '0;
            if (idx <= 4'd13) begin
              // Length fits in this block (words 14/15).
              blk[1]  <= len_nxt[63:32];
              blk[0]  <= len_nxt[31:0];
              final_f <= 1'b1;
            end else begin
              // No room for the length: an extra block follows. If every
              // byte of the last word was data, the 0x80 moves there too.
              extra <= 1'b1;
              p80   <= (pad_bytes == 3'd4);
            end
            cf_start <= 1'b1;
          end
        end
        RUN: if (done_fire) begin
          v <= cf_v_out;
          if (!final_f) begin
            if (extra) begin
              blk      <= '0;
              blk[15]  <= p80 ? 32'h8000_0000 : 32'h0;
              blk[1]   <= len[63:32];
              blk[0]   <= len[31:0];
              extra    <= 1'b0;
              p80      <= 1'b0;
              final_f  <= 1'b1;
              cf_start <= 1'b1;
            end else begin
              idx <= '0;
            end
          end
        end
        OUT: if (hash_ready) begin
          v       <= IV;
          len     <= '0;
          idx     <= '0;
          final_f <= 1'b0;
          extra   <= 1'b0;
          p80     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sm3_msg_ctrl.sv
// tb_sm3_msg_ctrl: directed bench for sm3_msg_ctrl with a behavioural SM3
// compression core answering cf_start after a fixed latency.
module tb_sm3_msg_ctrl;
  import sm3_pkg::*;

  localparam logic [255:0] H_ABC =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] H_64 =
    256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [255:0] H_EMPTY =
    256'h1ab21d83_55cfa17f_8e611948_31e81a8f_22bec8c7_28fefb74_7ed035eb_5082aa2b;
  localparam int CORE_LAT = 6;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         cf_start, cf_done = 1'b0;
  logic [511:0] cf_block;
  logic [255:0] cf_v_in, cf_v_out = '0, hash;
  logic         hash_valid, hash_ready = 1'b0, busy;

  int checks = 0, errors = 0, cyc = 0;

  sm3_msg_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .cf_start(cf_start), .cf_block(cf_block), .cf_v_in(cf_v_in),
    .cf_done(cf_done), .cf_v_out(cf_v_out),
    .hash_valid(hash_valid), .hash(hash), .hash_ready(hash_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- SM3 compression reference ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [0:67];
    logic [31:0] w1 [0:63];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(a, 12) + e + rl(t, j % 32), 7);
      ss2 = ss1 ^ rl(a, 12);
      tt1 = ((j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c))) + d + ss2 + w1[j];
      tt2 = ((j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g))) + h + ss1 + w[j];
      d = c; c = rl(bb, 9); bb = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  // ---------------- compression core model ----------------
  logic [511:0] core_blk = '0;
  logic [255:0] core_v = '0;
  int core_cnt = 0, nstart = 0, ndone = 0;
  logic [511:0] blk_log [0:3];
  int start_cyc [0:3];
  int done_cyc [0:3];

  always @(negedge clk) begin
    cf_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        cf_v_out = sm3_cf(core_v, core_blk);
        cf_done  = 1'b1;
        if (ndone < 4) done_cyc[ndone] = cyc;
        ndone++;
      end
    end
    if (cf_start) begin
      core_blk = cf_block;
      core_v   = cf_v_in;
      core_cnt = CORE_LAT;
      if (nstart < 4) begin
        blk_log[nstart]   = cf_block;
        start_cyc[nstart] = cyc;
      end
      nstart++;
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_hash(output int at);
    int t = 0;
    while (!hash_valid && t < 500) begin @(negedge clk); t++; end
    at = cyc;
    if (!hash_valid) begin
      checks++; errors++;
      $display("FAIL wait_hash_timeout: hash_valid=%b required 1", hash_valid);
    end
  endtask

  task automatic take_hash();
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    checks++; if (cf_start !== 1'b0) begin errors++; $display("FAIL rst_cf_start: got %b exp 0", cf_start); end
    checks++; if (cf_block !== '0) begin errors++; $display("FAIL rst_cf_block: got %h exp 0", cf_block); end
    checks++; if (cf_v_in !== IV) begin errors++; $display("FAIL rst_cf_v_in: got %h exp %h", cf_v_in, IV); end
    checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL rst_hash_valid: got %b exp 0", hash_valid); end
    checks++; if (hash !== IV) begin errors++; $display("FAIL rst_hash: got %h exp %h", hash, IV); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
  endtask

  task automatic test_abc();
    logic [511:0] eb;
    int at;
    eb = '0; eb[511:480] = 32'h61626380; eb[31:0] = 32'h00000018;
    nstart = 0; ndone = 0;
    send_word(32'h61626300, 1'b1, 3'd3);
    checks++; if (cf_start !== 1'b1) begin errors++; $display("FAIL abc_start_latency: cf_start=%b exp 1", cf_start); end
    checks++; if (cf_block !== eb) begin errors++; $display("FAIL abc_block: got %h exp %h", cf_block, eb); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abc_run_flags: in_ready=%b busy=%b exp 0/1", in_ready, busy); end
    wait_hash(at);
    checks++; if (hash !== H_ABC) begin errors++; $display("FAIL abc_hash: got %h exp %h", hash, H_ABC); end
    checks++; if (at !== done_cyc[0] + 1) begin errors++; $display("FAIL abc_valid_latency: cycle %0d exp %0d", at, done_cyc[0] + 1); end
    checks++; if (nstart !== 1) begin errors++; $display("FAIL abc_starts: got %0d exp 1", nstart); end
    take_hash();
    checks++; if (in_ready !== 1'b1 || hash !== IV) begin errors++; $display("FAIL abc_after_hs: in_ready=%b hash=%h exp 1/%h", in_ready, hash, IV); end
  endtask

  task automatic test_two_block();
    logic [511:0] e1, e2;
    int at, c0;
    e1 = {16{32'h61626364}};
    e2 = '0; e2[511:480] = 32'h80000000; e2[31:0] = 32'h00000200;
    nstart = 0; ndone = 0;
    c0 = cyc;
    for (int i = 0; i < 15; i++) send_word(32'h61626364, 1'b0, 3'd0);
    send_word(32'h61626364, 1'b1, 3'd4);
    checks++; if (cyc - c0 !== 16) begin errors++; $display("FAIL two_no_bubbles: %0d cycles exp 16", cyc - c0); end
    checks++; if (cf_start !== 1'b1) begin errors++; $display("FAIL two_start_latency: cf_start=%b exp 1", cf_start); end
    wait_hash(at);
    checks++; if (nstart !== 2) begin errors++; $display("FAIL two_starts: got %0d exp 2", nstart); end
    checks++; if (blk_log[0] !== e1) begin errors++; $display("FAIL two_block1: got %h exp %h", blk_log[0], e1); end
    checks++; if (blk_log[1] !== e2) begin errors++; $display("FAIL two_block2: got %h exp %h", blk_log[1], e2); end
    checks++; if (start_cyc[1] !== done_cyc[0] + 1) begin errors++; $display("FAIL two_extra_latency: cycle %0d exp %0d", start_cyc[1], done_cyc[0] + 1); end
    checks++; if (hash !== H_64) begin errors++; $display("FAIL two_hash: got %h exp %h", hash, H_64); end
    checks++; if (at !== done_cyc[1] + 1) begin errors++; $display("FAIL two_valid_latency: cycle %0d exp %0d", at, done_cyc[1] + 1); end
    take_hash();
  endtask

  task automatic test_empty();
    logic [511:0] eb;
    int at;
    eb = '0; eb[511:480] = 32'h80000000;
    nstart = 0; ndone = 0;
    send_word(32'h0, 1'b1, 3'd0);
    checks++; if (cf_block !== eb) begin errors++; $display("FAIL empty_block: got %h exp %h", cf_block, eb); end
    wait_hash(at);
    checks++; if (hash !== H_EMPTY) begin errors++; $display("FAIL empty_hash: got %h exp %h", hash, H_EMPTY); end
    checks++; if (nstart !== 1) begin errors++; $display("FAIL empty_starts: got %0d exp 1", nstart); end
    take_hash();
  endtask

  task automatic test_idx14();
    logic [511:0] e1, e2;
    logic [255:0] eh;
    int at;
    e1 = {{14{32'h11223344}}, 32'hAABB8000, 32'h00000000};
    e2 = '0; e2[31:0] = 32'h000001D0;
    eh = sm3_cf(sm3_cf(IV, e1), e2);
    nstart = 0; ndone = 0;
    for (int i = 0; i < 14; i++) send_word(32'h11223344, 1'b0, 3'd0);
    send_word(32'hAABBCCDD, 1'b1, 3'd2);
    checks++; if (cf_block !== e1) begin errors++; $display("FAIL idx14_block1: got %h exp %h", cf_block, e1); end
    wait_hash(at);
    checks++; if (blk_log[1] !== e2) begin errors++; $display("FAIL idx14_block2: got %h exp %h", blk_log[1], e2); end
    checks++; if (nstart !== 2) begin errors++; $display("FAIL idx14_starts: got %0d exp 2", nstart); end
    checks++; if (hash !== eh) begin errors++; $display("FAIL idx14_hash: got %h exp %h", hash, eh); end
    take_hash();
  endtask

  task automatic test_hold();
    int at;
    nstart = 0; ndone = 0;
    send_word(32'h61626300, 1'b1, 3'd3);
    wait_hash(at);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (hash_valid !== 1'b1 || hash !== H_ABC || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b in_ready=%b hash=%h exp 1/0/%h", i, hash_valid, in_ready, hash, H_ABC);
      end
      @(negedge clk);
    end
    take_hash();
    checks++; if (in_ready !== 1'b1 || hash_valid !== 1'b0) begin errors++; $display("FAIL hold_release: in_ready=%b valid=%b exp 1/0", in_ready, hash_valid); end
    test_abc();
    test_abc();
  endtask

  task automatic test_rst_mid_run();
    nstart = 0; ndone = 0;
    send_word(32'h61626300, 1'b1, 3'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || cf_start !== 1'b0 || hash_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstrun_flags: in_ready=%b start=%b valid=%b busy=%b exp 1/0/0/0", in_ready, cf_start, hash_valid, busy);
    end
    checks++; if (cf_v_in !== IV || hash !== IV || cf_block !== '0) begin
      errors++; $display("FAIL rstrun_state: v=%h hash=%h exp IV, block zero=%b", cf_v_in, hash, cf_block == '0);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (ndone !== 1) begin errors++; $display("FAIL rstrun_late_done: ndone=%0d exp 1", ndone); end
    checks++; if (in_ready !== 1'b1 || hash_valid !== 1'b0 || busy !== 1'b0 || cf_v_in !== IV) begin
      errors++; $display("FAIL rstrun_ignored: in_ready=%b valid=%b busy=%b v=%h", in_ready, hash_valid, busy, cf_v_in);
    end
    test_abc();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_empty();
    test_idx14();
    test_hold();
    test_rst_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
